// File: rtl/reg_pair_pkg.sv
// Shared encodings for the register-pair sequencer: op codes, pair codes,
// register-file selects, sequencer states and the pair-to-select mapping.
package reg_pair_pkg;

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_INC = 2'd2;
    localparam logic [1:0] OP_DEC = 2'd3;

    localparam logic [1:0] PAIR_BC = 2'd0;
    localparam logic [1:0] PAIR_DE = 2'd1;
    localparam logic [1:0] PAIR_HL = 2'd2;
    localparam logic [1:0] PAIR_AP = 2'd3;

    localparam logic [2:0] SEL_B    = 3'd0;
    localparam logic [2:0] SEL_C    = 3'd1;
    localparam logic [2:0] SEL_D    = 3'd2;
    localparam logic [2:0] SEL_E    = 3'd3;
    localparam logic [2:0] SEL_H    = 3'd4;
    localparam logic [2:0] SEL_L    = 3'd5;
    localparam logic [2:0] ZERO_SEL = 3'd6;
    localparam logic [2:0] SEL_A    = 3'd7;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WR_LO = 3'd2;
    localparam logic [2:0] ST_WR_HI = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    typedef struct packed {
        logic [2:0] hi;
        logic [2:0] lo;
    } pair_sel_t;

    // The A-pair's low half is the hard-wired zero register.
    function automatic pair_sel_t pair_sels(input logic [1:0] pair);
        pair_sel_t s;
        case (pair)
            PAIR_BC: s = '{hi: SEL_B, lo: SEL_C};
            PAIR_DE: s = '{hi: SEL_D, lo: SEL_E};
            PAIR_HL: s = '{hi: SEL_H, lo: SEL_L};
            default: s = '{hi: SEL_A, lo: ZERO_SEL};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/reg_pair_arb.sv
// Two-requester arbiter. Fixed priority (req 0 first) by default; define
// REG_PAIR_CTRL_RR_EN for a round-robin pointer advanced on each accept.
module reg_pair_arb (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

`ifdef REG_PAIR_CTRL_RR_EN
    logic prio1_q;
    logic prio1_d;

    // After serving req 0 the pointer favours req 1, and vice versa.
    always_comb begin
        prio1_d = prio1_q;
        if (advance_i) prio1_d = gnt_o[0];
    end

    always_ff @(posedge clock) begin
        if (reset) prio1_q <= 1'b0;
        else       prio1_q <= prio1_d;
    end

    always_comb begin
        gnt_o = 2'b00;
        if (prio1_q) begin
            if (req_i[1])      gnt_o = 2'b10;
            else if (req_i[0]) gnt_o = 2'b01;
        end else begin
            if (req_i[0])      gnt_o = 2'b01;
            else if (req_i[1]) gnt_o = 2'b10;
        end
    end
`else
    logic unused_fixed;
    assign unused_fixed = ^{clock, reset, advance_i};

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0])      gnt_o = 2'b01;
        else if (req_i[1]) gnt_o = 2'b10;
    end
`endif

endmodule

// File: rtl/reg_pair_ctrl.sv
// Sequences 16-bit pair RD/WR/INC/DEC into 8-bit register-file accesses and
// shares the port between two requesters. Optional macro: REG_PAIR_CTRL_RR_EN.
module reg_pair_ctrl
    import reg_pair_pkg::*;
#(
    parameter int OP_W   = 2,
    parameter int PAIR_W = 2,
    parameter int SEL_W  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*OP_W-1:0]   req_op,
    input  logic [2*PAIR_W-1:0] req_pair,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    output logic                resp_id,
    output logic [15:0]         resp_data,
    output logic                busy,
    output logic [SEL_W-1:0]    rf_out1_sel,
    output logic [SEL_W-1:0]    rf_out2_sel,
    input  logic [7:0]          rf_out1,
    input  logic [7:0]          rf_out2,
    output logic [7:0]          rf_data_in,
    output logic [SEL_W-1:0]    rf_data_in_sel,
    output logic                rf_write_reg
);

    logic [2:0]        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [PAIR_W-1:0] pair_q, pair_d;
    logic              id_q, id_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;

    logic [1:0]        gnt;
    logic              accept;
    logic              win;
    logic [OP_W-1:0]   op_in;
    pair_sel_t         sels;

    // Wraps modulo 2^16; the A-pair result keeps only the byte that A can hold.
    function automatic logic [15:0] pair_step(input logic [15:0] v, input logic dec,
                                              input logic zero_lo);
        logic [15:0] r;
        r = dec ? (v - 16'd1) : (v + 16'd1);
        if (zero_lo) r[7:0] = 8'h00;
        return r;
    endfunction

    reg_pair_arb u_arb (
        .clock     (clock),
        .reset     (reset),
        .req_i     (req_valid),
        .advance_i (accept),
        .gnt_o     (gnt)
    );

    assign req_ready = (state_q == ST_IDLE && !reset) ? gnt : 2'b00;
    assign accept    = |req_ready;
    assign win       = req_ready[1];
    assign op_in     = win ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pair_d  = pair_q;
        id_d    = id_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = op_in;
                    pair_d  = win ? req_pair[2*PAIR_W-1:PAIR_W] : req_pair[PAIR_W-1:0];
                    id_d    = win;
                    wdata_d = win ? req_wdata[31:16] : req_wdata[15:0];
                    state_d = (op_in == OP_WR) ? ST_WR_LO : ST_READ;
                end
            end
            ST_READ: begin
                rdata_d = {rf_out1, rf_out2};
                if (op_q == OP_RD) begin
                    state_d = ST_RESP;
                end else begin
                    wdata_d = pair_step({rf_out1, rf_out2}, op_q == OP_DEC, pair_q == PAIR_AP);
                    state_d = ST_WR_LO;
                end
            end
            ST_WR_LO: state_d = ST_WR_HI;
            ST_WR_HI: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        op_q    <= op_d;
        pair_q  <= pair_d;
        id_q    <= id_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    // Register-file and response outputs depend only on registered state;
    // reset gates the write strobe so an aborted sequence writes nothing more.
    always_comb begin
        sels           = pair_sels(pair_q);
        busy           = (state_q != ST_IDLE);
        rf_out1_sel    = '0;
        rf_out2_sel    = '0;
        rf_data_in     = 8'h00;
        rf_data_in_sel = '0;
        rf_write_reg   = 1'b0;
        resp_valid     = 1'b0;
        resp_id        = 1'b0;
        resp_data      = 16'h0000;
        case (state_q)
            ST_READ: begin
                rf_out1_sel = sels.hi;
                rf_out2_sel = sels.lo;
            end
            ST_WR_LO: begin
                rf_write_reg   = !reset;
                rf_data_in_sel = sels.lo;
                rf_data_in     = wdata_q[7:0];
            end
            ST_WR_HI: begin
                rf_write_reg   = !reset;
                rf_data_in_sel = sels.hi;
                rf_data_in     = wdata_q[15:8];
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_id    = id_q;
                resp_data  = (op_q == OP_RD) ? rdata_q : wdata_q;
            end
            default: ;
        endcase
    end

endmodule
